// File: rtl/seq_restoring_div16_8_if.sv
// Operand/result handshake bundle for the sequential restoring divider.
// master drives operands and out_ready; slave is the divider.
interface seq_restoring_div16_8_if #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  out_valid;
  logic                  out_ready;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output in_valid, dividend, divisor, out_ready,
    input  in_ready, out_valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  in_valid, dividend, divisor, out_ready,
    output in_ready, out_valid, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_div16_8.sv
// Unsigned restoring divider, one quotient bit per cycle: result DIVIDEND_W+1 cycles after accept (1 for /0).
// Single op in flight: in_ready only in IDLE, result held in DONE until out_ready.
module seq_restoring_div16_8 #(
  parameter int DIVIDEND_W = 16,
  parameter int DIVISOR_W  = 8
) (
  input logic                    clk,
  input logic                    rst_n,
  seq_restoring_div16_8_if.slave dif
);
  localparam int CNT_W  = $clog2(DIVIDEND_W + 1);
  // One extra bit so the shifted-in dividend bit can never overflow the partial remainder.
  localparam int PART_W = DIVISOR_W + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  in_ready_q, in_ready_d;
  logic                  out_valid_q, out_valid_d;
  logic [DIVIDEND_W-1:0] quo_sh_q, quo_sh_d;
  logic [DIVIDEND_W-1:0] quotient_q, quotient_d;
  logic [PART_W-1:0]     part_q, part_d;
  logic [DIVISOR_W-1:0]  dvs_q, dvs_d;
  logic [DIVISOR_W-1:0]  rem_q, rem_d;
  logic                  dbz_q, dbz_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic                  accept;
  logic                  last_step;
  logic [PART_W:0]       shifted;
  logic [PART_W+1:0]     trial;
  logic                  step_bit;
  logic [PART_W-1:0]     part_step;
  logic [DIVIDEND_W-1:0] quo_step;

  assign accept    = dif.in_valid & in_ready_q;
  assign last_step = (cnt_q == CNT_W'(DIVIDEND_W - 1));

  // Restoring step: bring down the next dividend bit, keep the difference only if it did not borrow.
  assign shifted   = {part_q, quo_sh_q[DIVIDEND_W-1]};
  assign trial     = {1'b0, shifted} - {{(PART_W + 2 - DIVISOR_W){1'b0}}, dvs_q};
  assign step_bit  = ~trial[PART_W+1];
  assign part_step = step_bit ? PART_W'(trial) : PART_W'(shifted);
  assign quo_step  = {quo_sh_q[DIVIDEND_W-2:0], step_bit};

  always_comb begin
    state_d    = state_q;
    quo_sh_d   = quo_sh_q;
    quotient_d = quotient_q;
    part_d     = part_q;
    dvs_d      = dvs_q;
    rem_d      = rem_q;
    dbz_d      = dbz_q;
    cnt_d      = cnt_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          dbz_d = 1'b0;
          if (dif.divisor == '0) begin
            quotient_d = '1;
            rem_d      = '0;
            dbz_d      = 1'b1;
            state_d    = DONE;
          end else begin
            quo_sh_d = dif.dividend;
            dvs_d    = dif.divisor;
            part_d   = '0;
            cnt_d    = '0;
            state_d  = BUSY;
          end
        end
      end
      BUSY: begin
        quo_sh_d = quo_step;
        part_d   = part_step;
        cnt_d    = cnt_q + 1'b1;
        if (last_step) begin
          quotient_d = quo_step;
          rem_d      = DIVISOR_W'(part_step);
          state_d    = DONE;
        end
      end
      DONE: begin
        if (dif.out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Handshake flags are registered from the next state so in_ready stays low in the cycle reset is released.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      quo_sh_q    <= '0;
      quotient_q  <= '0;
      part_q      <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      dbz_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      quo_sh_q    <= quo_sh_d;
      quotient_q  <= quotient_d;
      part_q      <= part_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      dbz_q       <= dbz_d;
      cnt_q       <= cnt_d;
    end
  end

  assign dif.in_ready    = in_ready_q;
  assign dif.out_valid   = out_valid_q;
  assign dif.quotient    = quotient_q;
  assign dif.remainder   = rem_q;
  assign dif.div_by_zero = dbz_q;
endmodule

// File: tb/tb_seq_restoring_div16_8.sv
// Directed and randomized checks of seq_restoring_div16_8 against an arithmetic reference.
module tb_seq_restoring_div16_8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_err = 0;

  seq_restoring_div16_8_if #(.DIVIDEND_W(16), .DIVISOR_W(8)) dif ();

  seq_restoring_div16_8 #(.DIVIDEND_W(16), .DIVISOR_W(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .dif   (dif)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one division, optionally stalling out_ready, and compare against plain arithmetic.
  task automatic do_op(input logic [15:0] a, input logic [7:0] b, input int stall);
    int          cyc;
    int          elat;
    logic [15:0] eq;
    logic [7:0]  er;
    logic        ez;
    if (b == 8'd0) begin
      eq = 16'hFFFF; er = 8'd0; ez = 1'b1; elat = 1;
    end else begin
      eq = a / {8'd0, b}; er = 8'(a % {8'd0, b}); ez = 1'b0; elat = 17;
    end
    cyc = 0;
    while (!dif.in_ready && cyc < 50) begin
      tick();
      cyc++;
    end
    check("in_ready_before_accept", 32'(dif.in_ready), 32'd1);
    dif.in_valid  = 1'b1;
    dif.dividend  = a;
    dif.divisor   = b;
    dif.out_ready = (stall == 0);
    tick();
    dif.in_valid = 1'b0;
    dif.dividend = 16'($urandom);
    dif.divisor  = 8'($urandom);
    cyc = 1;
    while (!dif.out_valid && cyc < 50) begin
      tick();
      cyc++;
    end
    check("latency", 32'(cyc), 32'(elat));
    check("quotient", 32'(dif.quotient), 32'(eq));
    check("remainder", 32'(dif.remainder), 32'(er));
    check("div_by_zero", 32'(dif.div_by_zero), 32'(ez));
    for (int i = 0; i < stall; i++) begin
      dif.in_valid = 1'b1;
      tick();
      check("hold_out_valid", 32'(dif.out_valid), 32'd1);
      check("hold_in_ready", 32'(dif.in_ready), 32'd0);
      check("hold_quotient", 32'(dif.quotient), 32'(eq));
      check("hold_remainder", 32'(dif.remainder), 32'(er));
    end
    dif.in_valid  = 1'b0;
    dif.out_ready = 1'b1;
    tick();
    check("out_valid_drop", 32'(dif.out_valid), 32'd0);
    check("in_ready_after_release", 32'(dif.in_ready), 32'd1);
    check("dbz_kept_in_idle", 32'(dif.div_by_zero), 32'(ez));
  endtask

  initial begin
    logic [15:0] ra;
    logic [7:0]  rb;
    dif.in_valid  = 1'b0;
    dif.dividend  = '0;
    dif.divisor   = '0;
    dif.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    tick(); tick(); tick();
    check("rst_in_ready", 32'(dif.in_ready), 32'd0);
    check("rst_out_valid", 32'(dif.out_valid), 32'd0);
    check("rst_quotient", 32'(dif.quotient), 32'd0);
    check("rst_remainder", 32'(dif.remainder), 32'd0);
    check("rst_dbz", 32'(dif.div_by_zero), 32'd0);
    rst_n = 1'b1;
    check("in_ready_before_release_edge", 32'(dif.in_ready), 32'd0);
    tick();
    check("in_ready_after_release_edge", 32'(dif.in_ready), 32'd1);

    // Directed values from the plan
    do_op(16'h3A5C, 8'h5B, 0);
    do_op(16'h3A98, 8'h4B, 0);
    do_op(16'hFFFF, 8'h01, 0);
    do_op(16'h00FF, 8'h10, 0);
    do_op(16'h0005, 8'hFF, 0);
    do_op(16'h0000, 8'h37, 0);
    do_op(16'h1234, 8'h00, 0);
    do_op(16'h0C35, 8'h07, 0);
    do_op(16'hFFFF, 8'hFF, 0);

    // Backpressure with ignored in_valid
    do_op(16'hBEEF, 8'h2D, 5);

    // Reset in the middle of BUSY
    while (!dif.in_ready) tick();
    dif.in_valid = 1'b1;
    dif.dividend = 16'hABCD;
    dif.divisor  = 8'h13;
    tick();
    dif.in_valid = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_out_valid", 32'(dif.out_valid), 32'd0);
    check("midrst_quotient", 32'(dif.quotient), 32'd0);
    check("midrst_remainder", 32'(dif.remainder), 32'd0);
    check("midrst_in_ready", 32'(dif.in_ready), 32'd0);
    begin
      int spurious;
      spurious = 0;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (dif.out_valid) spurious++;
      end
      check("midrst_no_spurious", 32'(spurious), 32'd0);
    end
    do_op(16'h0064, 8'h0A, 0);

    // Randomized operands and stalls
    for (int k = 0; k < 40; k++) begin
      ra = 16'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if (k % 5 == 1) ra = 16'($urandom_range(0, 300));
      do_op(ra, rb, int'($urandom_range(0, 3)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_restoring_div16_8.md
Name: seq_restoring_div16_8

Overview:
- Multi-cycle restoring divider: divides a 16-bit dividend by an 8-bit divisor, returning a 16-bit quotient and an 8-bit remainder.
- Performs the inverse operation of the 8x8 recursive multipliers, with the same operand widths.
- Used in the accuracy-characterisation datapath to recover operands from products, exact and approximate, and to compute relative-error terms.
- Valid/ready handshake on both sides; one operation in flight at a time.

Parameters:
- DIVIDEND_W, 16, dividend and quotient width; also the iteration count.
- DIVISOR_W, 8, divisor and remainder width; must be ≤ DIVIDEND_W.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset.
- in_valid  input  1  operands present.
- in_ready  output  1  block can accept operands.
- dividend  input  DIVIDEND_W  numerator, unsigned.
- divisor  input  DIVISOR_W  denominator, unsigned.
- out_valid  output  1  result present.
- out_ready  input  1  consumer accepts result.
- quotient  output  DIVIDEND_W  floor(dividend/divisor).
- remainder  output  DIVISOR_W  dividend mod divisor.
- div_by_zero  output  1  result came from a zero divisor.

Behaviour:
- Reset: clk is the only clock; rst_n is synchronous and active-low.
  - While rst_n=0 at a clk edge: state=IDLE, in_ready=0, out_valid=0, quotient=0, remainder=0, div_by_zero=0, and all internal registers are cleared.
  - in_ready rises in the first cycle after rst_n returns high.
- State IDLE:
  - in_ready=1, out_valid=0.
  - An accept occurs on a clk edge with in_valid=1 and in_ready=1.
  - On accept with divisor≠0: latch the dividend into the quotient shift register, latch the divisor, clear the partial remainder (DIVISOR_W+1 bits), set count=0, and go to BUSY.
  - On accept with divisor=0: quotient={DIVIDEND_W{1}}, remainder=0, div_by_zero=1, go to DONE. No BUSY cycles occur.
- State BUSY: in_ready=0. Each cycle performs one restoring step:
  - Shift {partial remainder, quotient reg} left by 1.
  - Trial = partial − divisor.
  - If trial is non-negative, partial=trial and the new quotient LSB=1; otherwise partial is kept and the LSB=0.
  - count increments. After DIVIDEND_W steps, go to DONE.
- State DONE:
  - out_valid=1; quotient, remainder and div_by_zero are registered outputs, held stable while out_valid=1 and out_ready=0.
  - On a clk edge with out_ready=1: out_valid drops and the state returns to IDLE. div_by_zero is cleared at the next accept.
- Latency, divisor≠0:
  - Accept edge at cycle 0; BUSY occupies cycles 1..DIVIDEND_W.
  - out_valid=1 from cycle DIVIDEND_W+1 (cycle 17 by default).
  - Throughput is one operation per DIVIDEND_W+2 cycles at best (out_ready tied 1).
- Latency, divisor=0: out_valid=1 in cycle 1.
- No input skid buffer; in_valid while in_ready=0 is ignored. Operands need not be held after accept.
- in_ready=1 only in IDLE; no accept may occur in the same cycle as out_valid handshake completion.
- Width rule: the partial remainder is DIVISOR_W+1 bits so a shifted-in MSB cannot overflow. The final remainder is always < divisor and fits in DIVISOR_W bits.
- Reset mid-operation (BUSY or DONE): abort, and all outputs take their reset values at that edge. No result is emitted for the aborted operation.
- Edge values:
  - dividend=0 gives q=0, r=0.
  - divisor=1 gives q=dividend, r=0.
  - dividend<divisor gives q=0, r=dividend[DIVISOR_W-1:0].

Test Plan:
- Reset then 0x3A5C / 0x5B, out_ready=1 → in_ready=1 the cycle after reset release; out_valid rises exactly 17 cycles after accept; q=0x00A4, r=0x10, div_by_zero=0.
- Round-trip of an exact product: 0x3A98 (200×75) / 0x4B → q=0x00C8, r=0x00.
- Edge values:
  - 0xFFFF / 0x01 → q=0xFFFF, r=0x00.
  - 0x00FF / 0x10 → q=0x000F, r=0x0F.
  - 0x0005 / 0xFF → q=0x0000, r=0x05.
- Divide by zero: 0x1234 / 0x00 → out_valid the cycle after accept; q=0xFFFF, r=0x00, div_by_zero=1; the next accepted op clears the flag.
- Backpressure:
  - Hold out_ready=0 for 5 cycles after out_valid → outputs stable, in_ready=0, and a new in_valid is ignored.
  - Raise out_ready → in_ready=1 the next cycle.
- Reset mid-op: rst_n=0 at BUSY count 8 for 1 cycle → out_valid, quotient and remainder read 0. No spurious result appears; the next operation (0x0064/0x0A) yields q=0x000A, r=0x00.
